// File: rtl/pwm_ascii_formatter_pkg.sv
// Shared constants for the PWM duty-cycle ASCII formatter.
//   - ASCII codes for digits and line termination
//   - formatter FSM state encoding (3-bit)
//   - default width/digit-count parameters
//   - pow10 helper used for the elaboration-time capacity check
package pwm_ascii_formatter_pkg;

  localparam int DATA_WIDTH_DEF = 17;
  localparam int NUM_DIGITS_DEF = 6;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CONVERT    = 3'd1,
    ST_SEND_DIGIT = 3'd2,
    ST_SEND_CR    = 3'd3,
    ST_SEND_LF    = 3'd4
  } fmt_state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_ascii_formatter_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   start_i  : load data_i and clear the BCD register
//   data_i   : binary value to convert
//   done_o   : one-cycle pulse, bcd_o is final from this cycle on
//   bcd_o    : NUM_DIGITS_P packed BCD nibbles, digit 0 in the low nibble
// bcd_o stays stable after done_o until the next start_i.
module pwm_ascii_formatter_bin2bcd_seq
  import pwm_ascii_formatter_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH_DEF,
  parameter int NUM_DIGITS_P = NUM_DIGITS_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [DATA_WIDTH_P-1:0]   data_i,
  output logic                      done_o,
  output logic [NUM_DIGITS_P*4-1:0] bcd_o
);

  localparam int BCD_W = NUM_DIGITS_P * 4;
  localparam int CNT_W = $clog2(DATA_WIDTH_P + 1);

  logic [DATA_WIDTH_P-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic                    done_q, done_d;
  logic [BCD_W-1:0]        adj;

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    adj     = bcd_q;
    for (int i = 0; i < NUM_DIGITS_P; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    if (start_i) begin
      shift_d = data_i;
      bcd_d   = '0;
      cnt_d   = CNT_W'(DATA_WIDTH_P);
      run_d   = 1'b1;
    end else if (run_q) begin
      // Adjust first, then shift the combined {bcd, shift} left by one.
      {bcd_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/pwm_ascii_formatter.sv
// Formats each duty-cycle count as a decimal ASCII line ("<digits>\r\n")
// and streams it one byte at a time over a valid/ready handshake.
//   Clk_i        : system clock, rising edge
//   Reset_i      : asynchronous active-low reset
//   Enable_i     : one-cycle strobe, Data_i valid
//   Data_i       : duty-cycle count
//   Byte_ready_i : downstream accepts a byte this cycle
//   Byte_o       : ASCII byte (held when Byte_valid_o is low)
//   Byte_valid_o : Byte_o holds a byte to transfer
//   Busy_o       : conversion or line transmission in progress
//   Overrun_o    : sticky, a strobe arrived while busy and was dropped
//
// state         | meaning
// ST_IDLE       | waiting for Enable_i
// ST_CONVERT    | double dabble running; first digit presented when done
// ST_SEND_DIGIT | presenting digit nibble[idx], idx counts down to 0
// ST_SEND_CR    | presenting carriage return
// ST_SEND_LF    | presenting line feed; its transfer ends the line
module pwm_ascii_formatter
  import pwm_ascii_formatter_pkg::*;
#(
  parameter int DATA_WIDTH_P     = DATA_WIDTH_DEF,
  parameter int NUM_DIGITS_P     = NUM_DIGITS_DEF,
  parameter int SUPPRESS_ZEROS_P = 1
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic                    Enable_i,
  input  logic [DATA_WIDTH_P-1:0] Data_i,
  input  logic                    Byte_ready_i,
  output logic [7:0]              Byte_o,
  output logic                    Byte_valid_o,
  output logic                    Busy_o,
  output logic                    Overrun_o
);

  localparam int          IDX_W   = (NUM_DIGITS_P > 1) ? $clog2(NUM_DIGITS_P) : 1;
  localparam int          BCD_W   = NUM_DIGITS_P * 4;
  localparam logic [63:0] MAX_BIN = (64'd1 << DATA_WIDTH_P) - 64'd1;
  localparam logic [63:0] MAX_DEC = pow10(NUM_DIGITS_P) - 64'd1;

  if (MAX_BIN > MAX_DEC) begin : g_bad_digit_capacity
    $error("pwm_ascii_formatter: NUM_DIGITS_P too small for DATA_WIDTH_P");
  end

  fmt_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             start;
  logic             xfer;
  logic             conv_done;
  logic [BCD_W-1:0] bcd;
  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       sel_nib;

  pwm_ascii_formatter_bin2bcd_seq #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .NUM_DIGITS_P (NUM_DIGITS_P)
  ) u_bin2bcd_seq (
    .clk_i   (Clk_i),
    .rst_n_i (Reset_i),
    .start_i (start),
    .data_i  (Data_i),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    start     = 1'b0;
    xfer      = valid_q & Byte_ready_i;

    // Most-significant nonzero digit; digit 0 is always printed.
    first_idx = '0;
    for (int i = 0; i < NUM_DIGITS_P; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) begin
        first_idx = IDX_W'(i);
      end
    end
    if (SUPPRESS_ZEROS_P == 0) begin
      first_idx = IDX_W'(NUM_DIGITS_P - 1);
    end

    // Digit to load next: the first one out of CONVERT, otherwise the next lower.
    sel_idx = (state_q == ST_CONVERT) ? first_idx : (idx_q - IDX_W'(1));
    sel_nib = '0;
    for (int i = 0; i < NUM_DIGITS_P; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_nib = bcd[i*4 +: 4];
      end
    end

    if (Enable_i && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (Enable_i) begin
          start   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          idx_d   = first_idx;
          byte_d  = ASCII_ZERO + {4'h0, sel_nib};
          valid_d = 1'b1;
          state_d = ST_SEND_DIGIT;
        end
      end
      ST_SEND_DIGIT: begin
        if (xfer) begin
          if (idx_q == '0) begin
            byte_d  = ASCII_CR;
            state_d = ST_SEND_CR;
          end else begin
            idx_d  = idx_q - IDX_W'(1);
            byte_d = ASCII_ZERO + {4'h0, sel_nib};
          end
        end
      end
      ST_SEND_CR: begin
        if (xfer) begin
          byte_d  = ASCII_LF;
          state_d = ST_SEND_LF;
        end
      end
      ST_SEND_LF: begin
        if (xfer) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign Byte_o       = byte_q;
  assign Byte_valid_o = valid_q;
  assign Busy_o       = busy_q;
  assign Overrun_o    = overrun_q;

endmodule

// File: doc/pwm_ascii_formatter.md
Name: pwm_ascii_formatter

Overview:
Converts each duty-cycle measurement (clock-count, from pwm_monitor) into a decimal ASCII line for the serial console. Sits between pwm_monitor (Duty_Cycle_o/Available_o) and the UART transmitter. Streams one byte at a time over a valid/ready handshake: digits, leading zeros suppressed, then CR LF. Example: 125000 counts at 50 MHz (2.5 ms) is sent as "125000\r\n".

Parameters:
DATA_WIDTH_P, 17, width of binary duty-cycle count.
NUM_DIGITS_P, 6, decimal digit capacity; elaboration error if 2^DATA_WIDTH_P-1 > 10^NUM_DIGITS_P-1.
SUPPRESS_ZEROS_P, 1, 1 = drop leading zeros (at least one digit is always sent); 0 = always send NUM_DIGITS_P digits.

Ports:
Clk_i  input  1  system clock; all state on rising edge.
Reset_i  input  1  asynchronous, active-low reset.
Enable_i  input  1  one-cycle strobe: Data_i valid (from pwm_monitor Available_o).
Data_i  input  DATA_WIDTH_P  duty-cycle count to print.
Byte_ready_i  input  1  UART transmitter can accept a byte this cycle.
Byte_o  output  8  ASCII byte.
Byte_valid_o  output  1  Byte_o holds a byte to transfer.
Busy_o  output  1  conversion or line transmission in progress.
Overrun_o  output  1  sticky: Enable_i arrived while Busy_o high.

Behaviour:
- Reset (Reset_i=0, async): state IDLE, Byte_o=8'h00, Byte_valid_o=0, Busy_o=0, Overrun_o=0, BCD/shift registers cleared. Reset mid-line aborts immediately; no partial byte completes; first Enable_i after release starts a fresh line.
- Transfer rule: a byte moves on a rising edge where Byte_valid_o=1 and Byte_ready_i=1. While Byte_valid_o=1 and not accepted, Byte_o stays stable and Byte_valid_o stays high. Byte_ready_i is ignored when Byte_valid_o=0.
- States: IDLE -> CONVERT -> SEND_DIGIT -> SEND_CR -> SEND_LF -> IDLE.
- IDLE: Enable_i=1 captures Data_i into the shift register, clears the BCD register, sets Busy_o=1 (next cycle), goes to CONVERT.
- CONVERT: sequential double-dabble, one bit per cycle. Each cycle, every BCD nibble >=5 gets +3, then {bcd,shift} shifts left by 1. Exactly DATA_WIDTH_P cycles. On the last cycle, the digit index is set to the most-significant nonzero nibble (index 0 if all zero, or NUM_DIGITS_P-1 if SUPPRESS_ZEROS_P=0), and Byte_valid_o=1 with the first digit.
- Latency: Byte_valid_o rises DATA_WIDTH_P+1 edges after the capturing edge (18 for defaults).
- SEND_DIGIT: Byte_o = 8'h30 + nibble[index]. On transfer: if index=0 go to SEND_CR with Byte_o=8'h0D; else decrement index and present the next digit. No bubble cycle between consecutive bytes when Byte_ready_i is held high.
- SEND_CR: on transfer go to SEND_LF, Byte_o=8'h0A.
- SEND_LF: on transfer, Byte_valid_o=0, Busy_o=0, go to IDLE. Busy_o drops on the same edge that transfers LF.
- Enable_i while Busy_o=1 (including the LF-transfer edge): sample is dropped and Overrun_o is set until reset. Enable_i in IDLE on the edge after LF transfer is accepted normally.
- Data_i is sampled only on the capturing edge; later changes have no effect on the line.
- Byte_o holds its last value when Byte_valid_o=0. Checkers must not compare it then.

Decomposition:
- Shared include (alongside the existing servo parameter file): ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, state encodings (3-bit), default DATA_WIDTH_P/NUM_DIGITS_P.
- One sub-module: bin2bcd_seq (start/done, DATA_WIDTH_P cycles, NUM_DIGITS_P*4-bit output). The top holds the FSM, handshake, digit index and overrun flag.

Test Plan:
- Data_i=125000, Byte_ready_i=1 -> bytes 31 32 35 30 30 30 0D 0A on 8 consecutive cycles; first valid 18 edges after capture; Busy_o low after LF.
- Data_i=0 -> bytes 30 0D 0A only. Data_i=25000 (0.5 ms) -> 32 35 30 30 30 0D 0A. Data_i=131071 -> 31 33 31 30 37 31 0D 0A.
- Data_i=75000 with Byte_ready_i low for 5 cycles at each byte -> Byte_o/Byte_valid_o held stable; the stream is still exactly 37 35 30 30 30 0D 0A with no duplicates.
- Second Enable_i 3 cycles after the first (Data_i=99) -> first line unchanged, Overrun_o=1 and sticky; Enable_i after LF -> 39 39 0D 0A.
- Reset_i low while the second digit is pending -> Byte_valid_o/Busy_o low asynchronously; after release, Data_i=7 -> 37 0D 0A.
- SUPPRESS_ZEROS_P=0, Data_i=42 -> 30 30 30 30 34 32 0D 0A.
